// File: rtl/luhn_stream_checker_if.sv
// -----------------------------------------------------------------------------
// luhn_stream_checker_if
// Digit stream in / result out bundle for luhn_stream_checker.
//   s_valid/s_ready  : digit handshake (s_digit BCD, s_last, s_mode)
//   m_valid/m_ready  : result handshake (m_pass, m_check, m_len, m_err)
// modport slave  : the checker's view
// modport master : the producer/consumer's view
// -----------------------------------------------------------------------------
interface luhn_stream_checker_if #(
    parameter int LEN_W = 5
) ();
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_digit;
    logic             s_last;
    logic             s_mode;
    logic             m_valid;
    logic             m_ready;
    logic             m_pass;
    logic [3:0]       m_check;
    logic [LEN_W-1:0] m_len;
    logic             m_err;

    modport slave (
        input  s_valid, s_digit, s_last, s_mode, m_ready,
        output s_ready, m_valid, m_pass, m_check, m_len, m_err
    );

    modport master (
        output s_valid, s_digit, s_last, s_mode, m_ready,
        input  s_ready, m_valid, m_pass, m_check, m_len, m_err
    );
endinterface

// File: rtl/luhn_stream_checker.sv
// -----------------------------------------------------------------------------
// luhn_stream_checker
// Streaming Luhn validate/generate engine, one BCD digit per beat, MSD first.
// Two parity accumulators (S0: doubles even index, S1: doubles odd index) let
// the final length pick the right sum without knowing it in advance.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : luhn_stream_checker_if.slave (digit stream in, result out)
// -----------------------------------------------------------------------------
module luhn_stream_checker #(
    parameter int MIN_DIGITS = 12,
    parameter int MAX_DIGITS = 19,
    parameter int LEN_W      = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    luhn_stream_checker_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_DIGITS + 1);
    localparam logic [LEN_W-1:0] V_MIN   = LEN_W'(MIN_DIGITS);
    localparam logic [LEN_W-1:0] V_MAX   = LEN_W'(MAX_DIGITS);
    localparam logic [LEN_W-1:0] G_MIN   = LEN_W'(MIN_DIGITS - 1);
    localparam logic [LEN_W-1:0] G_MAX   = LEN_W'(MAX_DIGITS - 1);

    logic [1:0]       state_q, state_d;
    logic             mode_q,  mode_d;
    logic [3:0]       s0_q,    s0_d;
    logic [3:0]       s1_q,    s1_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             bad_q,   bad_d;
    logic             pass_q,  pass_d;
    logic [3:0]       check_q, check_d;
    logic [LEN_W-1:0] mlen_q,  mlen_d;
    logic             err_q,   err_d;

    // Modular add; the 6-bit intermediate covers non-BCD digits too, whose
    // results are suppressed by the error flag anyway.
    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [4:0] b);
        logic [5:0] t;
        t = {2'b00, a} + {1'b0, b};
        if (t >= 6'd10) t = t - 6'd10;
        return t[3:0];
    endfunction

    logic             accept, first, mode_cur, odd_idx;
    logic [3:0]       d;
    logic [4:0]       d_ext, dbl;
    logic [3:0]       base_s0, base_s1, s0_n, s1_n, sum;
    logic [LEN_W-1:0] base_len, len_n;
    logic             bad_n, legal, fin_err;

    // IDLE starts a fresh PAN: accumulators, length and error are taken as zero.
    assign accept   = bus.s_valid && (state_q != ST_DONE);
    assign first    = (state_q == ST_IDLE);
    assign mode_cur = first ? bus.s_mode : mode_q;
    assign base_s0  = first ? 4'd0 : s0_q;
    assign base_s1  = first ? 4'd0 : s1_q;
    assign base_len = first ? '0 : len_q;
    assign odd_idx  = base_len[0];

    assign d     = bus.s_digit;
    assign d_ext = {1'b0, d};
    assign dbl   = (d <= 4'd4) ? {d, 1'b0} : ({d, 1'b0} - 5'd9);

    assign s0_n  = add_mod10(base_s0, odd_idx ? d_ext : dbl);
    assign s1_n  = add_mod10(base_s1, odd_idx ? dbl : d_ext);
    assign len_n = (base_len == LEN_SAT) ? LEN_SAT : base_len + 1'b1;
    assign bad_n = (!first && bad_q) || (d > 4'd9);

    // Validate: rightmost digit undoubled -> S0 when n even.
    // Generate: check digit lands at index n -> S0 when n odd.
    assign sum   = (mode_cur ^ len_n[0]) ? s1_n : s0_n;
    assign legal = mode_cur ? ((len_n >= G_MIN) && (len_n <= G_MAX))
                            : ((len_n >= V_MIN) && (len_n <= V_MAX));
    assign fin_err = bad_n || !legal || (len_n == LEN_SAT);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        len_d   = len_q;
        bad_d   = bad_q;
        pass_d  = pass_q;
        check_d = check_q;
        mlen_d  = mlen_q;
        err_d   = err_q;
        if (accept) begin
            mode_d = mode_cur;
            s0_d   = s0_n;
            s1_d   = s1_n;
            len_d  = len_n;
            bad_d  = bad_n;
            if (bus.s_last) begin
                state_d = ST_DONE;
                mlen_d  = len_n;
                err_d   = fin_err;
                pass_d  = !mode_cur && (sum == 4'd0) && !fin_err;
                check_d = (mode_cur && !fin_err && (sum != 4'd0)) ? 4'd10 - sum : 4'd0;
            end else begin
                state_d = ST_ACCUM;
            end
        end else if ((state_q == ST_DONE) && bus.m_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            len_q   <= '0;
            bad_q   <= 1'b0;
            pass_q  <= 1'b0;
            check_q <= '0;
            mlen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            len_q   <= len_d;
            bad_q   <= bad_d;
            pass_q  <= pass_d;
            check_q <= check_d;
            mlen_q  <= mlen_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_ready = (state_q != ST_DONE);
    assign bus.m_valid = (state_q == ST_DONE);
    assign bus.m_pass  = pass_q;
    assign bus.m_check = check_q;
    assign bus.m_len   = mlen_q;
    assign bus.m_err   = err_q;

endmodule
